// File: rtl/fp_status_pkg.sv
// ---------------------------------------------------------------------------
// Module : fp_status_pkg
// Brief  : Shared types and constants for the FP multiply status generator.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fp_status_pkg;

  // Status bit positions inside out_status / acc_flags
  localparam int unsigned ST_ZERO    = 0;
  localparam int unsigned ST_INF     = 1;
  localparam int unsigned ST_INVALID = 2;
  localparam int unsigned ST_TINY    = 3;
  localparam int unsigned ST_HUGE    = 4;
  localparam int unsigned ST_INEXACT = 5;

  // Internal exponent width: 10-bit input plus headroom for the
  // normalise and rounding increments so overflow is never masked.
  localparam int EXP_W = 12;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RUP = 2'd2,
    RND_RDN = 2'd3
  } rnd_mode_t;

  typedef enum logic [1:0] {
    CLS_NORM    = 2'd0,
    CLS_ZERO    = 2'd1,
    CLS_INF     = 2'd2,
    CLS_INVALID = 2'd3
  } cls_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] MAXNORM = 32'h7F7F_FFFF;
  localparam logic [31:0] INF     = 32'h7F80_0000;
  localparam logic [31:0] MINNORM = 32'h0080_0000;

  // One-hot mask for a status bit index
  function automatic logic [7:0] status_mask(input int unsigned idx);
    status_mask = 8'd1 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_unit.sv
// ---------------------------------------------------------------------------
// Module : fp_round_unit
// Brief  : Combinational rounding, overflow and underflow handling for a
//          normalised single-precision product (no subnormal support).
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fp_round_unit
  import fp_status_pkg::*;
(
  input  logic                    sign_i,
  input  logic signed [EXP_W-1:0] exp_i,
  input  logic [22:0]             frac_i,
  input  logic                    guard_i,
  input  logic                    sticky_i,
  input  rnd_mode_t               rnd_i,
  output logic [31:0]             result_o,
  output logic [7:0]              status_o
);

  localparam logic signed [EXP_W-1:0] EXP_OVF = 12'sd255;
  localparam logic signed [EXP_W-1:0] EXP_MIN = 12'sd1;

  logic                    inexact;
  logic                    inc;
  logic                    away;
  logic [23:0]             frac_sum;
  logic signed [EXP_W-1:0] exp_r;
  logic [31:0]             sign_word;

  // Round the fraction, then classify the post-round exponent range
  always_comb begin
    inexact = guard_i | sticky_i;
    case (rnd_i)
      RND_RNE: inc = guard_i & (sticky_i | frac_i[0]);
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = ~sign_i & inexact;
      RND_RDN: inc = sign_i & inexact;
      default: inc = 1'b0;
    endcase

    // A carry out of the fraction leaves the low 23 bits at zero
    frac_sum  = {1'b0, frac_i} + {23'd0, inc};
    exp_r     = exp_i + {{(EXP_W-1){1'b0}}, frac_sum[23]};
    // Directed modes rounding away from zero for this sign
    away      = ((rnd_i == RND_RUP) & ~sign_i) | ((rnd_i == RND_RDN) & sign_i);
    sign_word = {sign_i, 31'd0};

    if (exp_r >= EXP_OVF) begin
      status_o = status_mask(ST_HUGE) | status_mask(ST_INEXACT);
      result_o = ((rnd_i == RND_RNE) | away) ? (INF | sign_word) : (MAXNORM | sign_word);
    end else if (exp_r < EXP_MIN) begin
      status_o = status_mask(ST_TINY) | status_mask(ST_INEXACT);
      result_o = away ? (MINNORM | sign_word) : sign_word;
    end else begin
      status_o = inexact ? status_mask(ST_INEXACT) : 8'h00;
      result_o = {sign_i, exp_r[7:0], frac_sum[22:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_status_gen.sv
// ---------------------------------------------------------------------------
// Module : fp_status_gen
// Brief  : Two-stage FP multiply back end. S1 normalises the 48-bit product,
//          S2 rounds/classifies and holds the result under a valid/ready
//          handshake. Optional sticky accumulator of retired statuses.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fp_status_gen
  import fp_status_pkg::*;
#(
  parameter int ACC_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic [1:0]  in_cls,
  input  logic [1:0]  rnd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [7:0]  out_status,
  input  logic        acc_clr,
  output logic [7:0]  acc_flags
);

  // S1 registers
  logic                    s1_valid_q;
  logic                    s1_sign_q;
  logic signed [EXP_W-1:0] s1_exp_q;
  logic [22:0]             s1_frac_q;
  logic                    s1_guard_q;
  logic                    s1_sticky_q;
  cls_t                    s1_cls_q;
  rnd_mode_t               s1_rnd_q;

  // S1 next-state (normalised view of the incoming beat)
  logic signed [EXP_W-1:0] in_exp_ext;
  logic signed [EXP_W-1:0] s1_exp_d;
  logic [22:0]             s1_frac_d;
  logic                    s1_guard_d;
  logic                    s1_sticky_d;

  // S2 registers and next-state
  logic                    out_valid_q;
  logic [31:0]             out_result_q;
  logic [7:0]              out_status_q;
  logic [31:0]             out_result_d;
  logic [7:0]              out_status_d;

  logic                    s2_adv;
  logic                    retire;
  logic [31:0]             rnd_result;
  logic [7:0]              rnd_status;

  assign s2_adv     = ~out_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s2_adv;
  assign retire     = out_valid_q & out_ready;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_status = out_status_q;

  assign in_exp_ext = {{(EXP_W-10){in_exp[9]}}, in_exp};

  // Normalise: product is in [1,4), select the window below the leading one
  always_comb begin
    if (in_mant[47]) begin
      s1_frac_d   = in_mant[46:24];
      s1_guard_d  = in_mant[23];
      s1_sticky_d = |in_mant[22:0];
      s1_exp_d    = in_exp_ext + 12'sd1;
    end else begin
      s1_frac_d   = in_mant[45:23];
      s1_guard_d  = in_mant[22];
      s1_sticky_d = |in_mant[21:0];
      s1_exp_d    = in_exp_ext;
    end
  end

  // S1 capture; the stage refills whenever its contents can move on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_frac_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_cls_q    <= CLS_NORM;
      s1_rnd_q    <= RND_RNE;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q   <= in_sign;
        s1_exp_q    <= s1_exp_d;
        s1_frac_q   <= s1_frac_d;
        s1_guard_q  <= s1_guard_d;
        s1_sticky_q <= s1_sticky_d;
        s1_cls_q    <= cls_t'(in_cls);
        s1_rnd_q    <= rnd_mode_t'(rnd);
      end
    end
  end

  fp_round_unit u_round (
    .sign_i   (s1_sign_q),
    .exp_i    (s1_exp_q),
    .frac_i   (s1_frac_q),
    .guard_i  (s1_guard_q),
    .sticky_i (s1_sticky_q),
    .rnd_i    (s1_rnd_q),
    .result_o (rnd_result),
    .status_o (rnd_status)
  );

  // Special operand classes bypass the rounder with a single status bit
  always_comb begin
    out_result_d = rnd_result;
    out_status_d = rnd_status;
    case (s1_cls_q)
      CLS_ZERO: begin
        out_result_d = {s1_sign_q, 31'd0};
        out_status_d = status_mask(ST_ZERO);
      end
      CLS_INF: begin
        out_result_d = INF | {s1_sign_q, 31'd0};
        out_status_d = status_mask(ST_INF);
      end
      CLS_INVALID: begin
        out_result_d = QNAN;
        out_status_d = status_mask(ST_INVALID);
      end
      default: ;
    endcase
  end

  // S2 output register; frozen while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_status_q <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_result_q <= out_result_d;
        out_status_q <= out_status_d;
      end
    end
  end

  if (ACC_EN != 0) begin : g_acc
    logic [7:0] acc_q;

    // Sticky OR of retired statuses; a clear keeps only a coincident retire
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
      end else if (acc_clr) begin
        acc_q <= retire ? out_status_q : 8'h00;
      end else if (retire) begin
        acc_q <= acc_q | out_status_q;
      end
    end

    assign acc_flags = acc_q;
  end else begin : g_no_acc
    logic unused_acc;
    assign unused_acc = acc_clr ^ retire;
    assign acc_flags  = 8'h00;
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_status_gen.sv
// ---------------------------------------------------------------------------
// Module : tb_fp_status_gen
// Brief  : Self-checking bench for fp_status_gen with an arithmetic model.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_status_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic [1:0]  in_cls;
  logic [1:0]  rnd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [7:0]  out_status;
  logic        acc_clr;
  logic [7:0]  acc_flags;

  int vectors     = 0;
  int miscompares = 0;
  int retired     = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  model_acc = 8'h00;
  logic [39:0] mon_e;
  logic [7:0]  mon_est;
  bit          hold_prev = 1'b0;
  logic [31:0] prev_res;
  logic [7:0]  prev_st;

  fp_status_gen #(.ACC_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_cls     (in_cls),
    .rnd        (rnd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_status (out_status),
    .acc_clr    (acc_clr),
    .acc_flags  (acc_flags)
  );

  always #5 clk = ~clk;

  // Reference: real-valued rounding of top-24-bit significand, plain arithmetic
  function automatic logic [39:0] ref_model(input bit s, input int e, input logic [47:0] m,
                                            input int cls, input int rm);
    longint unsigned mant, top, rem, half;
    int sh, ee;
    bit g, st, inx, up, away;
    logic [31:0] sgn, res;
    logic [7:0] stat;
    sgn = s ? 32'h8000_0000 : 32'h0;
    if (cls == 1) return {sgn, 8'h01};
    if (cls == 2) return {sgn | 32'h7F80_0000, 8'h02};
    if (cls == 3) return {32'h7FC0_0000, 8'h04};
    mant = 64'(m);
    sh   = m[47] ? 24 : 23;
    ee   = e + (m[47] ? 1 : 0);
    top  = mant >> sh;
    rem  = mant - (top << sh);
    half = 64'd1 << (sh - 1);
    g    = rem >= half;
    st   = (rem % half) != 0;
    inx  = g || st;
    case (rm)
      0:       up = g && (st || (top % 2 == 1));
      1:       up = 1'b0;
      2:       up = !s && inx;
      default: up = s && inx;
    endcase
    top = top + (up ? 1 : 0);
    if (top == (64'd1 << 24)) begin
      top = 64'd1 << 23;
      ee  = ee + 1;
    end
    away = (rm == 2 && !s) || (rm == 3 && s);
    if (ee >= 255) begin
      stat = 8'h30;
      res  = (rm == 0 || away) ? (sgn | 32'h7F80_0000) : (sgn | 32'h7F7F_FFFF);
    end else if (ee <= 0) begin
      stat = 8'h28;
      res  = away ? (sgn | 32'h0080_0000) : sgn;
    end else begin
      stat = inx ? 8'h20 : 8'h00;
      res  = sgn | (32'(ee) << 23) | 32'(top % (64'd1 << 23));
    end
    return {res, stat};
  endfunction

  function automatic bit legal_status(input logic [7:0] st);
    if (st[7:6] != 2'b00) return 1'b0;
    if (st[2:0] != 3'b000) return (st == 8'h01) || (st == 8'h02) || (st == 8'h04);
    return 1'b1;
  endfunction

  // Scoreboard, hold-stability, status-legality and accumulator monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        vectors++;
        if (!legal_status(out_status)) begin
          miscompares++;
          $display("FAIL status_legal: got %02h, required a legal encoding", out_status);
        end
      end
      if (hold_prev) begin
        vectors++;
        if (!out_valid || out_result !== prev_res || out_status !== prev_st) begin
          miscompares++;
          $display("FAIL hold_stable: got v=%0b %08h/%02h, required v=1 %08h/%02h",
                   out_valid, out_result, out_status, prev_res, prev_st);
        end
      end
      vectors++;
      if (acc_flags !== model_acc) begin
        miscompares++;
        $display("FAIL acc_flags: got %02h, required %02h", acc_flags, model_acc);
      end
      mon_est = out_status;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got %08h/%02h, required no beat", out_result, out_status);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_est = mon_e[7:0];
          if ({out_result, out_status} !== mon_e) begin
            miscompares++;
            $display("FAIL retire_data: got %08h/%02h, required %08h/%02h",
                     out_result, out_status, mon_e[39:8], mon_e[7:0]);
          end
        end
        retired++;
      end
      if (acc_clr) model_acc = (out_valid && out_ready) ? mon_est : 8'h00;
      else if (out_valid && out_ready) model_acc = model_acc | mon_est;
      hold_prev = out_valid && !out_ready;
      prev_res  = out_result;
      prev_st   = out_status;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Present one beat (called at posedge+1) and hold it until accepted
  task automatic send(input bit s, input int e, input logic [47:0] m, input int cls, input int rm);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = 10'(e);
    in_mant  = m;
    in_cls   = 2'(cls);
    rnd      = 2'(rm);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_model(s, e, m, cls, rm));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout: got in_ready=0 for 100 cycles, required acceptance");
    in_valid = 1'b0;
  endtask

  // Advance to the negedge where out_valid is high (bounded)
  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || acc_flags !== 8'h00 || out_result !== 32'h0 || out_status !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got v=%0b acc=%02h res=%08h st=%02h, required all 0",
               out_valid, acc_flags, out_result, out_status);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed_round();
    logic [47:0] m_t[8]  = '{48'h6000_0000_0000, 48'h6000_0000_0000, 48'h6000_0000_0000,
                             48'h6000_0000_0000, 48'h6000_0000_0000, 48'h7FFF_FFC0_0000,
                             48'h7FFF_FFC0_0000, 48'hC000_0000_0000};
    int          e_t[8]  = '{128, 300, 300, -5, -5, 100, 254, 127};
    int          r_t[8]  = '{0, 0, 1, 0, 2, 0, 0, 0};
    logic [31:0] xr_t[8] = '{32'h4040_0000, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h0000_0000,
                             32'h0080_0000, 32'h3280_0000, 32'h7F80_0000, 32'h4040_0000};
    logic [7:0]  xs_t[8] = '{8'h00, 8'h30, 8'h30, 8'h28, 8'h28, 8'h20, 8'h30, 8'h00};
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, e_t[i], m_t[i], 0, r_t[i]);
      wait_out(ok);
      vectors++;
      if (!ok || out_result !== xr_t[i] || out_status !== xs_t[i]) begin
        miscompares++;
        $display("FAIL round_case%0d: got v=%0b %08h/%02h, required %08h/%02h",
                 i, ok, out_result, out_status, xr_t[i], xs_t[i]);
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_special_acc();
    bit ok;
    out_ready = 1'b1;
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    send(1'b0, 0, 48'h0, 3, 0);
    wait_out(ok);
    vectors++;
    if (!ok || out_result !== 32'h7FC0_0000 || out_status !== 8'h04) begin
      miscompares++;
      $display("FAIL invalid: got %08h/%02h, required 7fc00000/04", out_result, out_status);
    end
    @(posedge clk); #1;
    send(1'b1, 0, 48'h0, 1, 0);
    wait_out(ok);
    vectors++;
    if (!ok || out_result !== 32'h8000_0000 || out_status !== 8'h01) begin
      miscompares++;
      $display("FAIL neg_zero: got %08h/%02h, required 80000000/01", out_result, out_status);
    end
    @(posedge clk); #1;
    drain();
    vectors++;
    if (acc_flags !== 8'h05) begin
      miscompares++;
      $display("FAIL acc_sticky: got %02h, required 05", acc_flags);
    end
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    vectors++;
    if (acc_flags !== 8'h00) begin
      miscompares++;
      $display("FAIL acc_clear: got %02h, required 00", acc_flags);
    end
    send(1'b0, 0, 48'h0, 2, 0);
    wait_out(ok);
    vectors++;
    if (!ok || out_result !== 32'h7F80_0000 || out_status !== 8'h02) begin
      miscompares++;
      $display("FAIL pos_inf: got %08h/%02h, required 7f800000/02", out_result, out_status);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    bit rdy[3];
    int start_ret;
    start_ret = retired;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(i[0], 60 + i * 7, 48'h4000_0000_0000 | 48'(i * 48'h1_2345_6789), 0, i % 4);
      end
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          rdy[c] = in_ready;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    vectors++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1 || rdy[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_in_ready: got %0b%0b%0b, required 110", rdy[0], rdy[1], rdy[2]);
    end
    vectors++;
    if (retired - start_ret != 5) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d retired, required 5", retired - start_ret);
    end
  endtask

  task automatic test_random();
    int edges[8] = '{0, 1, 253, 254, 255, -1, -512, 511};
    bit done;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          logic [47:0] m;
          int e, cls;
          m = {16'($urandom), $urandom};
          if ($urandom_range(0, 1) == 1) m[47] = 1'b1;
          else begin
            m[47] = 1'b0;
            m[46] = 1'b1;
          end
          if ($urandom_range(0, 4) == 0) m[21:0] = '0;
          if ($urandom_range(0, 9) == 0) e = edges[$urandom_range(0, 7)];
          else e = int'($urandom_range(0, 300)) - 20;
          cls = ($urandom_range(0, 5) < 3) ? 0 : int'($urandom_range(1, 3));
          send(1'($urandom), e, m, cls, int'($urandom_range(0, 3)));
          if ($urandom_range(0, 15) == 0) begin
            acc_clr = 1'b1;
            @(posedge clk); #1;
            acc_clr = 1'b0;
          end
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    send(1'b0, 130, 48'h5000_0000_0000, 0, 0);
    send(1'b1, 140, 48'h9000_0000_0000, 0, 1);
    rst = 1'b1;
    exp_q.delete();
    model_acc = 8'h00;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || acc_flags !== 8'h00 || out_status !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%0b acc=%02h st=%02h, required 0/00/00",
               out_valid, acc_flags, out_status);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 128, 48'h6000_0000_0000, 0, 0);
    wait_out(ok);
    vectors++;
    if (!ok || out_result !== 32'h4040_0000 || out_status !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_resume: got v=%0b %08h/%02h, required 40400000/00",
               ok, out_result, out_status);
    end
    @(posedge clk); #1;
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_cls    = '0;
    rnd       = '0;
    out_ready = 1'b1;
    acc_clr   = 1'b0;
    test_reset();
    test_directed_round();
    test_special_acc();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_status_gen.md
FP_STATUS_GEN -- requirements
Module: fp_status_gen

Interface
REQ-001 SHALL have parameter ACC_EN, default 1, meaning 1 = sticky status accumulator present, 0 = acc_flags tied to 0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports in_valid  input  1  and in_ready  output  1, the input handshake.
REQ-005 SHALL have port in_sign  input  1  product sign.
REQ-006 SHALL have port in_exp  input  10  signed biased exponent, ea+eb-127.
REQ-007 SHALL have port in_mant  input  48  unsigned 24x24 mantissa product, hidden bits included.
REQ-008 SHALL have port in_cls  input  2  operand class: NORM=0, ZERO=1, INF=2, INVALID=3.
REQ-009 SHALL have port rnd  input  2  rounding mode: RNE=0, RTZ=1, RUP=2, RDN=3; sampled with the input beat.
REQ-010 SHALL have ports out_valid  output  1  and out_ready  input  1, the output handshake.
REQ-011 SHALL have port out_result  output  32  IEEE-754 single result.
REQ-012 SHALL have port out_status  output  8  status: [0] zero, [1] inf, [2] invalid, [3] tiny, [4] huge, [5] inexact, [7:6] always 0.
REQ-013 SHALL have ports acc_clr  input  1  and acc_flags  output  8, the sticky OR of accepted statuses.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 normalise, S2 round/classify; a beat accepted at edge N presents at edge N+2 when unstalled.
REQ-015 SHALL accept a beat iff in_valid&&in_ready, and retire a beat iff out_valid&&out_ready.
REQ-016 SHALL advance S2 when !s2_valid||out_ready, and drive in_ready = !s1_valid||S2-advance; sustain 1 beat/cycle.
REQ-017 SHALL hold out_result/out_status stable while out_valid&&!out_ready, with no beat lost, duplicated or reordered.
REQ-018 SHALL normalise: if mant[47], frac=mant[46:24], guard=mant[23], sticky=|mant[22:0], exp+1; else frac=mant[45:23], guard=mant[22], sticky=|mant[21:0].
REQ-019 SHALL round by mode:
  - RNE: increment on guard&&(sticky||frac[0]).
  - RTZ: never increment.
  - RUP: increment on !sign&&(guard||sticky).
  - RDN: increment on sign&&(guard||sticky).
  - Fraction carry-out SHALL give frac=0, exp+1.
REQ-020 SHALL, for NORM with 1<=post-round exp<=254, output the packed value with status[5]=guard||sticky and all other bits 0.
REQ-021 SHALL, for NORM with exp>=255 (overflow), set status 0x30 (huge+inexact, inf bit clear), with result:
  - signed infinity for RNE, or for RUP/RDN rounding toward the sign;
  - signed max-normal 0x7F7FFFFF|sign otherwise.
REQ-022 SHALL, for NORM with exp<=0 (underflow, no subnormals), set status 0x28 (tiny+inexact, zero bit clear), with result:
  - signed min-normal when RUP&&!sign or RDN&&sign;
  - signed zero otherwise.
REQ-023 SHALL output, for ZERO class, signed zero with status 0x01.
REQ-024 SHALL output, for INF class, signed infinity with status 0x02.
REQ-025 SHALL output, for INVALID class, 0x7FC00000 with status 0x04.
REQ-026 SHALL never output a status pairing zero/inf/invalid with any other bit, nor zero, inf or invalid with tiny, huge or inexact.
REQ-027 SHALL update acc_flags |= out_status on each retired beat; acc_clr clears it next edge; clear with a simultaneous retire leaves only that beat's status.

Reset
REQ-028 SHALL, while rst is high, clear both stage valids, out_valid, acc_flags, out_result and out_status to 0 asynchronously; in_ready is 1 after reset.
REQ-029 SHALL discard in-flight beats on reset mid-operation and resume accepting on the first edge after deassertion.

Structure
REQ-030 SHALL take from package fp_status_pkg: status-bit index constants, rnd_mode_t enum, cls_t enum, and the QNAN, MAXNORM and INF constants.
REQ-031 SHALL place combinational rounding (REQ-019..022) in sub-module fp_round_unit, instantiated in S2.

Verification
REQ-032 SHALL cover: exp=128, mant=0x600000000000, NORM, RNE -> result 0x40400000, status 0x00.
REQ-033 SHALL cover: exp=300, NORM -> RNE gives 0x7F800000, RTZ gives 0x7F7FFFFF, both status 0x30.
REQ-034 SHALL cover: exp=-5, sign=0, NORM -> RNE gives 0x00000000 status 0x28; RUP gives 0x00800000 status 0x28.
REQ-035 SHALL cover: INVALID -> 0x7FC00000/0x04; ZERO with sign=1 -> 0x80000000/0x01; acc_flags then 0x05; acc_clr -> 0x00.
REQ-036 SHALL cover: 5 back-to-back beats with out_ready low 3 cycles -> in_ready low after 2 held beats, all 5 retire in order.
REQ-037 SHALL cover: rst pulse with 2 beats in flight -> out_valid 0 and acc_flags 0 immediately; checker bound on out_status reports no violation throughout.
